// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 response codes and burst-length type.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [7:0] len_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_err_slv_r.sv
// axi_err_slv_r: read half of the error subordinate. Accepts one AR at a time and
// answers it with len+1 error beats. Define AXI_ERR_SLV_RESP_DATA_EN to drive
// RESP_DATA on every beat instead of zero.
module axi_err_slv_r
  import axi_pkg::*;
#(
  parameter int          ID_WIDTH   = 4,
  parameter int          DATA_WIDTH = 32,
  parameter resp_t       RESP       = RESP_DECERR,
  parameter logic [63:0] RESP_DATA  = 64'hCA11AB1E
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  len_t                  ar_len,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output resp_t                 r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready
);

`ifdef AXI_ERR_SLV_RESP_DATA_EN
  localparam logic [DATA_WIDTH-1:0] BEAT_DATA = DATA_WIDTH'(RESP_DATA);
`else
  localparam logic [DATA_WIDTH-1:0] BEAT_DATA = '0;
  logic unused_resp_data;
  assign unused_resp_data = ^RESP_DATA;
`endif

  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  r_state_e r_state, r_state_next;
  len_t     len_q, len_next;
  len_t     cnt_q, cnt_next;

  assign r_resp = RESP;

  // Next state, burst length and beat counter; the burst ends on the beat where cnt equals len.
  always_comb begin
    r_state_next = r_state;
    len_next     = len_q;
    cnt_next     = cnt_q;
    unique case (r_state)
      R_IDLE: begin
        if (ar_valid && ar_ready) begin
          r_state_next = R_DATA;
          len_next     = ar_len;
          cnt_next     = '0;
        end
      end
      R_DATA: begin
        if (r_valid && r_ready) begin
          if (r_last) r_state_next = R_IDLE;
          else        cnt_next     = cnt_q + 8'd1;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // State, counter and registered R/AR outputs derived from the next state so they change on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= r_state_next;
      len_q    <= len_next;
      cnt_q    <= cnt_next;
      ar_ready <= (r_state_next == R_IDLE);
      r_valid  <= (r_state_next == R_DATA);
      r_last   <= (r_state_next == R_DATA) && (cnt_next == len_next);
      r_data   <= BEAT_DATA;
      if (ar_valid && ar_ready) r_id <= ar_id;
    end
  end

endmodule

// File: rtl/axi_err_slv.sv
// axi_err_slv: AXI4 subordinate that terminates every transaction with an error
// response (one B per AW, len+1 R beats per AR). Macro AXI_ERR_SLV_RESP_DATA_EN
// makes R data carry RESP_DATA instead of zero.
module axi_err_slv
  import axi_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter int          USER_WIDTH = 1,
  parameter resp_t       RESP       = RESP_DECERR,
  parameter logic [63:0] RESP_DATA  = 64'hCA11AB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  len_t                    aw_len,
  input  logic [USER_WIDTH-1:0]   aw_user,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic [USER_WIDTH-1:0]   w_user,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output resp_t                   b_resp,
  output logic [USER_WIDTH-1:0]   b_user,
  output logic                    b_valid,
  input  logic                    b_ready,
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  len_t                    ar_len,
  input  logic [USER_WIDTH-1:0]   ar_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output resp_t                   r_resp,
  output logic                    r_last,
  output logic [USER_WIDTH-1:0]   r_user,
  output logic                    r_valid,
  input  logic                    r_ready
);

  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("axi_err_slv: ADDR_WIDTH must be >= 1");
  end
  if (ID_WIDTH < 1) begin : g_bad_id_width
    $error("axi_err_slv: ID_WIDTH must be >= 1");
  end
  if (USER_WIDTH < 1) begin : g_bad_user_width
    $error("axi_err_slv: USER_WIDTH must be >= 1");
  end
  if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_data_width
    $error("axi_err_slv: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e w_state, w_state_next;

  // Address, payload and user fields are never inspected: every request ends in an error.
  logic unused_inputs;
  assign unused_inputs = ^{aw_addr, aw_len, aw_user, w_data, w_strb, w_user, ar_addr, ar_user};

  assign b_resp = RESP;
  assign b_user = '0;
  assign r_user = '0;

  // Write sequencing: accept AW, swallow W beats up to w_last, then hold B until taken.
  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_valid && aw_ready)         w_state_next = W_DATA;
      W_DATA:  if (w_valid && w_ready && w_last) w_state_next = W_RESP;
      W_RESP:  if (b_valid && b_ready)           w_state_next = W_IDLE;
      default:                                   w_state_next = W_IDLE;
    endcase
  end

  // Write state and registered AW/W/B outputs; b_id is latched at AW acceptance and held through B.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
    end else begin
      w_state  <= w_state_next;
      aw_ready <= (w_state_next == W_IDLE);
      w_ready  <= (w_state_next == W_DATA);
      b_valid  <= (w_state_next == W_RESP);
      if (aw_valid && aw_ready) b_id <= aw_id;
    end
  end

  axi_err_slv_r #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESP       (RESP),
    .RESP_DATA  (RESP_DATA)
  ) u_read (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ar_id    (ar_id),
    .ar_len   (ar_len),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_id     (r_id),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_last   (r_last),
    .r_valid  (r_valid),
    .r_ready  (r_ready)
  );

endmodule

// File: tb/tb_axi_err_slv.sv
// tb_axi_err_slv: randomized bench for axi_err_slv with a transaction-level model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_axi_err_slv;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 2;
`ifdef AXI_ERR_SLV_RESP_DATA_EN
  localparam logic [DW-1:0] EXP_DATA = 32'hCA11AB1E;
`else
  localparam logic [DW-1:0] EXP_DATA = 32'h0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [IW-1:0]   awId = '0;
  logic [AW-1:0]   awAddr = '0;
  logic [7:0]      awLen = '0;
  logic [UW-1:0]   awUser = '0;
  logic            awValid = 1'b0;
  logic            awReady;
  logic [DW-1:0]   wData = '0;
  logic [DW/8-1:0] wStrb = '0;
  logic            wLast = 1'b0;
  logic [UW-1:0]   wUser = '0;
  logic            wValid = 1'b0;
  logic            wReady;
  logic [IW-1:0]   bId;
  logic [1:0]      bResp;
  logic [UW-1:0]   bUser;
  logic            bValid;
  logic            bReady = 1'b0;
  logic [IW-1:0]   arId = '0;
  logic [AW-1:0]   arAddr = '0;
  logic [7:0]      arLen = '0;
  logic [UW-1:0]   arUser = '0;
  logic            arValid = 1'b0;
  logic            arReady;
  logic [IW-1:0]   rId;
  logic [DW-1:0]   rData;
  logic [1:0]      rResp;
  logic            rLast;
  logic [UW-1:0]   rUser;
  logic            rValid;
  logic            rReady = 1'b0;

  int compareCount = 0;
  int mismatchCount = 0;

  // Transaction-level expectations: phase of the single outstanding write, read burst progress.
  bit         modelStarted = 1'b0;
  int         wrPhase = 0;
  bit         rdBusy = 1'b0;
  int         rdBeat = 0;
  int         expLen = 0;
  logic [3:0] expBId = '0;
  logic [3:0] expRId = '0;
  int         bDone = 0;
  int         rBeats = 0;
  int         rBursts = 0;
  int         rLastSeen = 0;
  logic [3:0] obsBId = '0;
  logic [3:0] obsRId = '0;

  axi_err_slv #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .USER_WIDTH (UW),
    .RESP       (2'b11),
    .RESP_DATA  (64'hCA11AB1E)
  ) dut (
    .clk_i    (clock),
    .rst_i    (reset),
    .aw_id    (awId),
    .aw_addr  (awAddr),
    .aw_len   (awLen),
    .aw_user  (awUser),
    .aw_valid (awValid),
    .aw_ready (awReady),
    .w_data   (wData),
    .w_strb   (wStrb),
    .w_last   (wLast),
    .w_user   (wUser),
    .w_valid  (wValid),
    .w_ready  (wReady),
    .b_id     (bId),
    .b_resp   (bResp),
    .b_user   (bUser),
    .b_valid  (bValid),
    .b_ready  (bReady),
    .ar_id    (arId),
    .ar_addr  (arAddr),
    .ar_len   (arLen),
    .ar_user  (arUser),
    .ar_valid (arValid),
    .ar_ready (arReady),
    .r_id     (rId),
    .r_data   (rData),
    .r_resp   (rResp),
    .r_last   (rLast),
    .r_user   (rUser),
    .r_valid  (rValid),
    .r_ready  (rReady)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name, input int waited);
    compareCount++;
    mismatchCount++;
    $display("[TB] FAIL timeout %s: waited %0d cycles without completion", name, waited);
  endtask

  // Model update from the handshakes the protocol rules say must occur on this edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelStarted <= 1'b0;
      wrPhase      <= 0;
      rdBusy       <= 1'b0;
      rdBeat       <= 0;
    end else begin
      modelStarted <= 1'b1;
      case (wrPhase)
        0: if (modelStarted && awValid) begin
             wrPhase <= 1;
             expBId  <= awId;
           end
        1: if (wValid && wLast) wrPhase <= 2;
        2: if (bReady) begin
             wrPhase <= 0;
             bDone   <= bDone + 1;
             obsBId  <= bId;
           end
        default: wrPhase <= 0;
      endcase
      if (!rdBusy) begin
        if (modelStarted && arValid) begin
          rdBusy <= 1'b1;
          expRId <= arId;
          expLen <= int'(arLen);
          rdBeat <= 0;
        end
      end else if (rReady) begin
        rBeats <= rBeats + 1;
        obsRId <= rId;
        if (rLast) rLastSeen <= rLastSeen + 1;
        if (rdBeat == expLen) begin
          rdBusy  <= 1'b0;
          rBursts <= rBursts + 1;
        end else begin
          rdBeat <= rdBeat + 1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, sampled mid-cycle.
  always @(negedge clock) begin
    checkOutput("aw_ready", 64'(awReady), 64'(modelStarted && wrPhase == 0));
    checkOutput("w_ready", 64'(wReady), 64'(wrPhase == 1));
    checkOutput("b_valid", 64'(bValid), 64'(wrPhase == 2));
    checkOutput("ar_ready", 64'(arReady), 64'(modelStarted && !rdBusy));
    checkOutput("r_valid", 64'(rValid), 64'(rdBusy));
    checkOutput("b_resp", 64'(bResp), 64'd3);
    checkOutput("r_resp", 64'(rResp), 64'd3);
    checkOutput("b_user", 64'(bUser), 64'd0);
    checkOutput("r_user", 64'(rUser), 64'd0);
    if (wrPhase == 2) checkOutput("b_id", 64'(bId), 64'(expBId));
    if (rdBusy) begin
      checkOutput("r_id", 64'(rId), 64'(expRId));
      checkOutput("r_last", 64'(rLast), 64'(rdBeat == expLen));
      checkOutput("r_data", 64'(rData), 64'(EXP_DATA));
    end
  end

  // One write (AW, len+1 W beats, B) or one read (AR, R until r_last); entered and left at posedge+1.
  task automatic applyStimulus(input bit isWrite, input logic [3:0] id, input logic [7:0] len, input bit randomReady);
    int waited;
    int beat;
    bit accepted;
    if (isWrite) begin
      awId = id; awLen = len; awAddr = $urandom; awUser = 2'($urandom_range(0, 3)); awValid = 1'b1;
      accepted = 1'b0; waited = 0;
      while (!accepted && waited < 100) begin
        @(posedge clock); accepted = awReady; waited++; #1;
      end
      awValid = 1'b0;
      if (!accepted) reportTimeout("aw accept", waited);
      beat = 0; waited = 0;
      while (beat <= int'(len) && waited < 2000) begin
        wValid = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        wLast  = (beat == int'(len));
        wData  = $urandom; wStrb = '1; wUser = 2'($urandom_range(0, 3));
        @(posedge clock);
        if (wValid && wReady) beat++;
        waited++; #1;
      end
      wValid = 1'b0; wLast = 1'b0;
      if (beat <= int'(len)) reportTimeout("w beats", waited);
      accepted = 1'b0; waited = 0;
      while (!accepted && waited < 100) begin
        bReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clock); accepted = bValid && bReady; waited++; #1;
      end
      bReady = 1'b0;
      if (!accepted) reportTimeout("b handshake", waited);
    end else begin
      arId = id; arLen = len; arAddr = $urandom; arUser = 2'($urandom_range(0, 3)); arValid = 1'b1;
      accepted = 1'b0; waited = 0;
      while (!accepted && waited < 100) begin
        @(posedge clock); accepted = arReady; waited++; #1;
      end
      arValid = 1'b0;
      if (!accepted) reportTimeout("ar accept", waited);
      accepted = 1'b0; waited = 0;
      while (!accepted && waited < 4000) begin
        rReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clock); accepted = rValid && rReady && rLast; waited++; #1;
      end
      rReady = 1'b0;
      if (!accepted) reportTimeout("r last", waited);
    end
  endtask

  // Hard stop in case a scenario wedges outside a bounded loop.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got no summary, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized concurrent traffic.
  initial begin
    int startB, startBeats, startLast, startBursts, waited;
    bit got;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset aw_ready", 64'(awReady), 64'd0);
    checkOutput("reset r_last", 64'(rLast), 64'd0);
    checkOutput("reset b_resp", 64'(bResp), 64'd3);
    checkOutput("reset r_data", 64'(rData), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("release aw_ready", 64'(awReady), 64'd1);
    checkOutput("release ar_ready", 64'(arReady), 64'd1);
    checkOutput("release b_valid", 64'(bValid), 64'd0);
    checkOutput("release r_valid", 64'(rValid), 64'd0);

    startB = bDone;
    applyStimulus(1'b1, 4'd3, 8'd3, 1'b0);
    checkOutput("aw3 b count", 64'(bDone - startB), 64'd1);
    checkOutput("aw3 b_id", 64'(obsBId), 64'd3);

    startBeats = rBeats; startLast = rLastSeen;
    applyStimulus(1'b0, 4'd5, 8'd0, 1'b0);
    checkOutput("ar5 beats", 64'(rBeats - startBeats), 64'd1);
    checkOutput("ar5 last", 64'(rLastSeen - startLast), 64'd1);
    checkOutput("ar5 r_id", 64'(obsRId), 64'd5);

    startBeats = rBeats; startLast = rLastSeen;
    applyStimulus(1'b0, 4'd6, 8'd255, 1'b0);
    checkOutput("len255 beats", 64'(rBeats - startBeats), 64'd256);
    checkOutput("len255 last", 64'(rLastSeen - startLast), 64'd1);

    startBeats = rBeats;
    applyStimulus(1'b0, 4'd4, 8'd7, 1'b1);
    checkOutput("backpressure beats", 64'(rBeats - startBeats), 64'd8);

    startB = bDone; startBursts = rBursts;
    fork
      applyStimulus(1'b1, 4'd1, 8'd2, 1'b1);
      applyStimulus(1'b0, 4'd2, 8'd3, 1'b1);
    join
    checkOutput("concurrent b count", 64'(bDone - startB), 64'd1);
    checkOutput("concurrent b_id", 64'(obsBId), 64'd1);
    checkOutput("concurrent r bursts", 64'(rBursts - startBursts), 64'd1);
    checkOutput("concurrent r_id", 64'(obsRId), 64'd2);

    arId = 4'd7; arLen = 8'd7; arValid = 1'b1;
    got = 1'b0; waited = 0;
    while (!got && waited < 50) begin
      @(posedge clock); got = arReady; waited++; #1;
    end
    arValid = 1'b0;
    if (!got) reportTimeout("reset-test ar accept", waited);
    rReady = 1'b1;
    got = 1'b0; waited = 0;
    while (!got && waited < 50) begin
      @(posedge clock); got = rValid && rReady; waited++; #1;
    end
    rReady = 1'b0;
    if (!got) reportTimeout("reset-test first beat", waited);
    checkOutput("beat2 r_valid", 64'(rValid), 64'd1);
    startBeats = rBeats;
    reset = 1'b1;
    #1;
    checkOutput("async r_valid", 64'(rValid), 64'd0);
    checkOutput("async ar_ready", 64'(arReady), 64'd0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0; rReady = 1'b1;
    repeat (6) @(posedge clock);
    #1 rReady = 1'b0;
    checkOutput("abandoned beats", 64'(rBeats - startBeats), 64'd0);
    startBeats = rBeats;
    applyStimulus(1'b0, 4'd9, 8'd1, 1'b0);
    checkOutput("ar9 beats", 64'(rBeats - startBeats), 64'd2);
    checkOutput("ar9 r_id", 64'(obsRId), 64'd9);

    for (int i = 0; i < 25; i++) begin
      bit doW, doR;
      logic [3:0] idW, idR;
      logic [7:0] lenW, lenR;
      doW = 1'($urandom_range(0, 1)); doR = 1'($urandom_range(0, 1));
      idW = 4'($urandom_range(0, 15)); idR = 4'($urandom_range(0, 15));
      lenW = 8'($urandom_range(0, 15)); lenR = 8'($urandom_range(0, 15));
      startBeats = rBeats;
      fork
        begin
          if (doW) applyStimulus(1'b1, idW, lenW, 1'b1);
        end
        begin
          if (doR) applyStimulus(1'b0, idR, lenR, 1'b1);
        end
      join
      if (doR) checkOutput("random beats", 64'(rBeats - startBeats), 64'(int'(lenR) + 1));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
